// File: rtl/apb_arb_pkg.sv
// apb_req_arbiter shared types and widths.
// Imported by the interface, the arbiter and the top.
package apb_arb_pkg;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and master-side bundle of apb_req_arbiter.
// slave: arbiter view; master: clients + APB master view.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    import apb_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_grant;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic                      m_transfer;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_done;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  m_done, m_rdata, m_err,
        output req_grant,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output m_transfer, m_write, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output m_done, m_rdata, m_err,
        input  req_grant,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  m_transfer, m_write, m_addr, m_wdata
    );

endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick starting at i_ptr.
// The pointer itself is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_any_req,
    output logic [ID_W-1:0]    o_winner
);

    // Scan from farthest to nearest so the nearest request wins.
    always_comb begin
        int w_idx;
        w_idx     = 0;
        o_any_req = 1'b0;
        o_winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(i_ptr) + i) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_winner  = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between NUM_REQ requesters.
// Round-robin grant, one transfer in flight, tagged response.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              pclk,
    input  logic              preset,
    apb_req_arbiter_if.slave  bus
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;

    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_cur_id;
    logic [TMO_W-1:0]    r_tmo;

    logic [NUM_REQ-1:0]  r_grant;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_m_transfer;
    logic                r_m_write;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;

    logic [ID_W-1:0]     w_ptr;
    logic [ID_W-1:0]     w_cur_id;
    logic [TMO_W-1:0]    w_tmo;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_rsp_valid;
    logic [ID_W-1:0]     w_rsp_id;
    logic [DATA_W-1:0]   w_rsp_rdata;
    logic                w_rsp_err;
    logic                w_m_transfer;
    logic                w_m_write;
    logic [ADDR_W-1:0]   w_m_addr;
    logic [DATA_W-1:0]   w_m_wdata;

    logic                w_any_req;
    logic [ID_W-1:0]     w_winner;
    logic                w_tmo_hit;
    logic                w_end;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_write;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    assign w_win_addr  = bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
    assign w_win_wdata = bus.req_wdata[int'(w_winner)*DATA_W +: DATA_W];
    assign w_win_write = bus.req_write[w_winner];
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_end       = bus.m_done | bus.m_err | w_tmo_hit;

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req) w_next = BUSY;
            BUSY:    if (w_end) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        w_ptr        = r_ptr;
        w_cur_id     = r_cur_id;
        w_tmo        = r_tmo;
        w_grant      = '0;
        w_rsp_valid  = 1'b0;
        w_rsp_id     = r_rsp_id;
        w_rsp_rdata  = r_rsp_rdata;
        w_rsp_err    = r_rsp_err;
        w_m_transfer = r_m_transfer;
        w_m_write    = r_m_write;
        w_m_addr     = r_m_addr;
        w_m_wdata    = r_m_wdata;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant      = NUM_REQ'(1) << w_winner;
                    w_cur_id     = w_winner;
                    w_m_transfer = 1'b1;
                    w_m_write    = w_win_write;
                    w_m_addr     = w_win_addr;
                    w_m_wdata    = w_win_wdata;
                    w_tmo        = '0;
                    if (w_winner == ID_W'(NUM_REQ - 1)) begin
                        w_ptr = '0;
                    end else begin
                        w_ptr = w_winner + ID_W'(1);
                    end
                end
            end
            BUSY: begin
                w_tmo = r_tmo + TMO_W'(1);
                if (w_end) begin
                    w_m_transfer = 1'b0;
                    w_rsp_valid  = 1'b1;
                    w_rsp_id     = r_cur_id;
                    if (bus.m_done) begin
                        w_rsp_rdata = r_m_write ? '0 : bus.m_rdata;
                        w_rsp_err   = bus.m_err;
                    end else begin
                        w_rsp_rdata = '0;
                        w_rsp_err   = 1'b1;
                    end
                end
            end
            RESP: begin
                w_m_transfer = 1'b0;
            end
            default: begin
                w_m_transfer = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset abandons any transfer.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_ptr        <= '0;
            r_cur_id     <= '0;
            r_tmo        <= '0;
            r_grant      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_m_transfer <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
        end else begin
            r_ptr        <= w_ptr;
            r_cur_id     <= w_cur_id;
            r_tmo        <= w_tmo;
            r_grant      <= w_grant;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_id     <= w_rsp_id;
            r_rsp_rdata  <= w_rsp_rdata;
            r_rsp_err    <= w_rsp_err;
            r_m_transfer <= w_m_transfer;
            r_m_write    <= w_m_write;
            r_m_addr     <= w_m_addr;
            r_m_wdata    <= w_m_wdata;
        end
    end

    assign bus.req_grant  = r_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.m_transfer = r_m_transfer;
    assign bus.m_write    = r_m_write;
    assign bus.m_addr     = r_m_addr;
    assign bus.m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter (4 requesters, TIMEOUT=8).
// Directed transfers push expectations; a monitor checks them.
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    typedef struct {
        logic [3:0]  grant;
        logic        wr;
        logic [32:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] rd;
        logic        err;
    } rexp_t;

    logic pclk;
    logic preset;
    int   checks;
    int   errors;
    int   cyc;

    gexp_t gq[$];
    rexp_t rq[$];
    int    gcyc[$];

    apb_req_arbiter_if #(.NUM_REQ(NREQ), .ID_W(2)) bus ();

    apb_req_arbiter #(
        .NUM_REQ (NREQ),
        .ID_W    (2),
        .TIMEOUT (TMO)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_exp(input int id, input bit wr,
                            input logic [32:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input logic err);
        gexp_t g;
        rexp_t r;
        g.grant = 4'(1) << id;
        g.wr    = wr;
        g.addr  = a;
        g.wd    = wd;
        r.id    = 2'(id);
        r.rd    = rd;
        r.err   = err;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(bus.req_grant), 0);
        chk({tag, "_rspv"},  64'(bus.rsp_valid), 0);
        chk({tag, "_rspid"}, 64'(bus.rsp_id), 0);
        chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 0);
        chk({tag, "_rerr"},  64'(bus.rsp_err), 0);
        chk({tag, "_xfer"},  64'(bus.m_transfer), 0);
        chk({tag, "_mwr"},   64'(bus.m_write), 0);
        chk({tag, "_maddr"}, 64'(bus.m_addr), 0);
        chk({tag, "_mwd"},   64'(bus.m_wdata), 0);
    endtask

    // One transfer; done_c/err_c are 1-based BUSY cycles (0 = never).
    task automatic run_xfer(input logic [3:0] mask, input int id,
                            input bit wr, input logic [32:0] a,
                            input logic [31:0] wd, input int done_c,
                            input int err_c, input logic [31:0] rd);
        int          endc;
        logic [31:0] erd;
        logic        eerr;
        bit          ok;
        endc = TMO;
        erd  = '0;
        eerr = 1'b1;
        for (int c = TMO; c >= 1; c--)
            if (c == done_c || c == err_c) endc = c;
        if (done_c == endc) begin
            erd  = wr ? 32'h0 : rd;
            eerr = (err_c == endc);
        end
        push_exp(id, wr, a, wd, erd, eerr);
        bus.req_write[id]          = wr;
        bus.req_addr[id*33 +: 33]  = a;
        bus.req_wdata[id*32 +: 32] = wd;
        bus.req_valid              = mask;
        tick();
        bus.req_valid = '0;
        for (int c = 1; c <= endc; c++) begin
            bus.m_done  = (c == done_c);
            bus.m_err   = (c == err_c);
            bus.m_rdata = rd;
            @(negedge pclk);
            ok = bus.m_transfer && bus.m_write == wr &&
                 bus.m_addr == a && bus.m_wdata == wd &&
                 bus.req_grant == ((c == 1) ? 4'(1) << id : 4'h0) &&
                 !bus.rsp_valid;
            chk("busy_hold", 64'(ok), 1);
            tick();
        end
        bus.m_done = 1'b0;
        bus.m_err  = 1'b0;
        @(negedge pclk);
        chk("rsp_timing", {62'h0, bus.rsp_valid, bus.m_transfer}, 2);
        tick();
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents one.
    always @(negedge pclk) begin
        if (!preset) begin
            if (bus.req_grant != '0) begin
                gcyc.push_back(cyc);
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 64'(bus.req_grant), 0);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    chk("grant_vec",  64'(bus.req_grant), 64'(g.grant));
                    chk("grant_xfer", 64'(bus.m_transfer), 1);
                    chk("grant_wr",   64'(bus.m_write), 64'(g.wr));
                    chk("grant_addr", 64'(bus.m_addr), 64'(g.addr));
                    chk("grant_wd",   64'(bus.m_wdata), 64'(g.wd));
                end
            end
            if (bus.rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("rsp_id",    64'(bus.rsp_id), 64'(r.id));
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rd));
                    chk("rsp_err",   64'(bus.rsp_err), 64'(r.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        preset = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_done    = 1'b0;
        bus.m_rdata   = '0;
        bus.m_err     = 1'b0;
        tick();
        tick();
        @(negedge pclk);
        chk_all_zero("reset");
        tick();
        preset = 1'b0;
        tick();

        // Fairness: all four pending, master completes at once.
        for (int i = 0; i < NREQ; i++)
            bus.req_addr[i*33 +: 33] = 33'h0_0000_0100 + 33'(i * 4);
        for (int k = 0; k < 5; k++)
            push_exp(k % 4, 1'b0, 33'h0_0000_0100 + 33'((k % 4) * 4),
                     32'h0, 32'h0BAD_0000, 1'b0);
        gcyc.delete();
        bus.m_done    = 1'b1;
        bus.m_rdata   = 32'h0BAD_0000;
        bus.req_valid = 4'hF;
        tick();
        for (int k = 0; k < 12; k++) tick();
        bus.req_valid = '0;
        tick();
        bus.m_done = 1'b0;
        tick();
        tick();
        chk("fair_count", 64'(gcyc.size()), 5);
        for (int i = 1; i < gcyc.size(); i++)
            chk("fair_gap", 64'(gcyc[i] - gcyc[i-1]), 3);

        // Single read, completion on 4th BUSY cycle.
        run_xfer(4'b0001, 0, 1'b0, 33'h0_0000_0010, 32'h0,
                 4, 0, 32'hDEAD_BEEF);
        // Write from requester 2, addr bit 32 set.
        run_xfer(4'b0100, 2, 1'b1, 33'h1_0000_0020, 32'h1234_5678,
                 2, 0, 32'hFFFF_FFFF);
        // Slave error on second BUSY cycle.
        run_xfer(4'b0010, 1, 1'b0, 33'h0_0000_0030, 32'h0,
                 0, 2, 32'h7777_7777);
        // Silent master: timeout.
        run_xfer(4'b1000, 3, 1'b0, 33'h1_FFFF_FFFC, 32'h0,
                 0, 0, 32'h1111_1111);
        // Completion on the last allowed cycle beats timeout.
        run_xfer(4'b0001, 0, 1'b0, 33'h0_0000_0040, 32'h0,
                 TMO, 0, 32'hCAFE_F00D);

        // Reset in the middle of a transfer: no response.
        begin
            gexp_t g;
            g.grant = 4'b0100;
            g.wr    = 1'b0;
            g.addr  = 33'h0_0000_0050;
            g.wd    = 32'h0;
            gq.push_back(g);
        end
        bus.req_write[2]          = 1'b0;
        bus.req_addr[2*33 +: 33]  = 33'h0_0000_0050;
        bus.req_wdata[2*32 +: 32] = 32'h0;
        bus.req_valid             = 4'b0100;
        tick();
        bus.req_valid = '0;
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        @(negedge pclk);
        chk_all_zero("rst_mid");
        tick();
        tick();
        // Pointer restarts at 0, so requester 1 beats requester 3.
        run_xfer(4'b1010, 1, 1'b0, 33'h0_0000_0060, 32'h0,
                 2, 0, 32'h55AA_55AA);

        tick();
        tick();
        chk("gq_empty", 64'(gq.size()), 0);
        chk("rq_empty", 64'(rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
